// File: rtl/icache_control.sv
// -----------------------------------------------------------------------------
// icache_control
//
// Control unit for a two-stage pipelined, two-way set-associative instruction
// cache. Stage 1 presents the fetch address to the datapath. Stage 2 carries
// the pipelined control word (pipe_mem_read, pipe_lru) together with the hit
// result.
//
// A hit completes in stage 2 with no added latency. A miss stalls the pipe and
// fills the LRU victim way from physical memory. It then spends one bubble
// cycle re-reading stage 1 before resuming.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   mem_read        stage-1 CPU fetch request (the datapath consumes it)
//   pipe_mem_read   stage-2 fetch request
//   hit             stage-2 tag match
//   pipe_lru        stage-2 LRU bit (1: way 0 most recently used)
//   pmem_resp       physical memory line read complete
//   count_clr       synchronous clear of both performance counters
//   load_pipeline   advance stage-1 -> stage-2 registers
//   read_data       enable data/tag array reads
//   load_data       per-way data array write enable
//   load_tag        per-way tag array write enable
//   set_valid0/1    set valid bit of way 0 / way 1
//   load_lru        write the LRU array
//   pmem_read       line read request to physical memory
//   mem_resp        fetch complete strobe to the CPU
//   hit_count       saturating hit counter
//   miss_count      saturating miss counter
// -----------------------------------------------------------------------------
module icache_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             pipe_mem_read,
   input  logic             hit,
   input  logic             pipe_lru,
   input  logic             pmem_resp,
   input  logic             count_clr,
   output logic             load_pipeline,
   output logic             read_data,
   output logic [1:0]       load_data,
   output logic [1:0]       load_tag,
   output logic             set_valid0,
   output logic             set_valid1,
   output logic             load_lru,
   output logic             pmem_read,
   output logic             mem_resp,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      RUN    = 2'd1,
      FETCH  = 2'd2,
      BUBBLE = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic             victim_reg, victim_next;
   logic             hit_inc, miss_inc;
   logic [CNT_W-1:0] hit_count_reg, miss_count_reg;

   // -------------------------------------------------------------------------
   // State and victim registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= INIT;
         victim_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         victim_reg <= victim_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      victim_next   = victim_reg;
      load_pipeline = 1'b0;
      read_data     = 1'b0;
      load_data     = 2'b00;
      load_tag      = 2'b00;
      set_valid0    = 1'b0;
      set_valid1    = 1'b0;
      load_lru      = 1'b0;
      pmem_read     = 1'b0;
      mem_resp      = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;

      unique case (state_reg)
         INIT: begin
            load_pipeline = 1'b1;
            read_data     = 1'b1;
            state_next    = RUN;
         end

         RUN: begin
            if (pipe_mem_read && !hit) begin
               // Stall both stages. pipe_lru set means way 0 was used last,
               // so way 1 is the victim. Otherwise way 0 is the victim.
               victim_next = pipe_lru;
               miss_inc    = 1'b1;
               state_next  = FETCH;
            end else begin
               load_pipeline = 1'b1;
               read_data     = 1'b1;
               if (pipe_mem_read) begin
                  mem_resp = 1'b1;
                  load_lru = 1'b1;
                  hit_inc  = 1'b1;
               end
            end
         end

         FETCH: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               load_data[victim_reg] = 1'b1;
               load_tag[victim_reg]  = 1'b1;
               set_valid0            = ~victim_reg;
               set_valid1            = victim_reg;
               load_lru              = 1'b1;
               mem_resp              = 1'b1;
               state_next            = BUBBLE;
            end
         end

         BUBBLE: begin
            // Re-read stage 1 one cycle after the array write. This avoids
            // returning stale data when stage 1 maps to the line just filled.
            load_pipeline = 1'b1;
            read_data     = 1'b1;
            state_next    = RUN;
         end

         default: begin
            state_next = INIT;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Saturating performance counters; clear wins over increment
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else if (count_clr) begin
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
      end else begin
         if (hit_inc && (hit_count_reg != {CNT_W{1'b1}}))
            hit_count_reg <= hit_count_reg + 1'b1;
         if (miss_inc && (miss_count_reg != {CNT_W{1'b1}}))
            miss_count_reg <= miss_count_reg + 1'b1;
      end
   end

   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;

endmodule

// File: doc/icache_control.md
ICACHE_CONTROL -- requirements
Module: icache_control

Interface
REQ-001 Parameter: CNT_W, 32, width of the hit and miss performance counters.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_read  input  1  CPU fetch request for the address currently presented to the datapath (stage 1).
REQ-005 pipe_mem_read  input  1  stage-2 copy of mem_read, from the pipelined control word.
REQ-006 hit  input  1  stage-2 hit from the datapath.
REQ-007 pipe_lru  input  1  stage-2 LRU bit; 1 means way 0 was most recently used.
REQ-008 pmem_resp  input  1  physical memory line-read complete.
REQ-009 count_clr  input  1  synchronous clear of both counters.
REQ-010 load_pipeline  output  1  advance the stage-1 to stage-2 registers.
REQ-011 read_data  output  1  enable data and tag array reads.
REQ-012 load_data  output  2  per-way data array write enable.
REQ-013 load_tag  output  2  per-way tag array write enable.
REQ-014 set_valid0, set_valid1  output  1 each  set valid bit of way 0 / way 1.
REQ-015 load_lru  output  1  write the LRU array.
REQ-016 pmem_read  output  1  line-read request to physical memory.
REQ-017 mem_resp  output  1  fetch-complete strobe to the CPU.
REQ-018 hit_count, miss_count  output  CNT_W each  performance counters.

Function
REQ-019 The FSM SHALL have exactly four states: INIT, RUN, FETCH, BUBBLE.
REQ-020 INIT SHALL last one cycle and drive load_pipeline=1 and read_data=1, with no response and no writes, then go to RUN.
REQ-021 In RUN with pipe_mem_read=0, or with pipe_mem_read=1 and hit=1, the FSM SHALL drive load_pipeline=1 and read_data=1.
REQ-022 In RUN with pipe_mem_read=1 and hit=1, the FSM SHALL assert mem_resp=1 and load_lru=1 in the same cycle (zero added latency), increment hit_count, and stay in RUN.
REQ-023 In RUN with pipe_mem_read=1 and hit=0, the FSM SHALL drive load_pipeline=0 and read_data=0.
REQ-024 On that miss cycle the FSM SHALL latch victim = pipe_lru (victim way 1 when pipe_lru=1, else way 0), increment miss_count, and go to FETCH.
REQ-025 In FETCH, pmem_read SHALL be 1 and load_pipeline SHALL be 0 every cycle until pmem_resp=1.
REQ-026 On the FETCH cycle with pmem_resp=1, the FSM SHALL assert load_data[victim], load_tag[victim], the matching set_valid, load_lru and mem_resp for exactly one cycle, then go to BUBBLE.
REQ-027 On any other cycle, both bits of load_data and load_tag SHALL be 0; the non-victim way's bits SHALL always be 0.
REQ-028 BUBBLE SHALL last one cycle with load_pipeline=1, read_data=1 and mem_resp=0, then go to RUN; this re-reads stage 1 after the array write and avoids a same-index read-during-write hazard.
REQ-029 pmem_read SHALL be 0 in INIT, RUN and BUBBLE; mem_resp SHALL never be asserted on two consecutive cycles across a miss.
REQ-030 The counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 count_clr SHALL zero both counters and take priority over a same-cycle increment.
REQ-032 All outputs SHALL be decoded from the state and inputs (Moore/Mealy mix as stated above) without a registered-output delay.

Reset
REQ-033 While rst=1, the state SHALL be INIT, victim SHALL be 0, and both counters SHALL be 0, regardless of clk.
REQ-034 While rst=1, pmem_read, mem_resp, load_lru, load_data, load_tag and set_valid* SHALL be 0 immediately.
REQ-035 Reset asserted during FETCH SHALL abandon the fill; no array write SHALL occur for it.
REQ-036 After rst deasserts, the first edge SHALL run INIT.

Verification
REQ-037 Hit stream: RUN, pipe_mem_read=1, hit=1 for 4 cycles -> mem_resp=1 and load_lru=1 on each cycle, hit_count=4, load_pipeline stays 1.
REQ-038 Miss, pipe_lru=1, pmem_resp after 5 cycles -> pmem_read=1 for 5 cycles; response cycle shows load_data=2'b10, load_tag=2'b10, set_valid1=1, mem_resp=1; then one BUBBLE cycle; then RUN; miss_count=1.
REQ-039 Miss with pipe_lru=0 and immediate pmem_resp -> load_data=2'b01 and set_valid0=1 on the first FETCH cycle.
REQ-040 Reset pulse on the third FETCH cycle -> pmem_read=0 with no clock edge; no load_* asserted; INIT then RUN follow deassertion.
REQ-041 With CNT_W=4: 16 hits -> hit_count=15 (held); count_clr together with a hit -> hit_count=0.
REQ-042 Idle: pipe_mem_read=0 for 10 cycles -> no mem_resp, no pmem_read, counters unchanged.
